// File: rtl/div_datapath_if.sv
// Controller/host-facing bundle of the divider datapath.
// The cyc_cnt signal and CNT_WIDTH exist only when DIV_CYCLE_CNT_EN is defined.
interface div_datapath_if #(
  parameter int WIDTH = 8
`ifdef DIV_CYCLE_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ini;
  logic             upd;
  logic             rdy;
  logic             err;
  logic             altb;
  logic             zero_b;
  logic             busy;
  logic             res_valid;
  logic             res_ack;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             res_err;
`ifdef DIV_CYCLE_CNT_EN
  logic [CNT_WIDTH-1:0] cyc_cnt;

  modport master (
    output a_in, b_in, ini, upd, rdy, err, res_ack,
    input  altb, zero_b, busy, res_valid, quotient, remainder, res_err, cyc_cnt
  );
  modport slave (
    input  a_in, b_in, ini, upd, rdy, err, res_ack,
    output altb, zero_b, busy, res_valid, quotient, remainder, res_err, cyc_cnt
  );
`else
  modport master (
    output a_in, b_in, ini, upd, rdy, err, res_ack,
    input  altb, zero_b, busy, res_valid, quotient, remainder, res_err
  );
  modport slave (
    input  a_in, b_in, ini, upd, rdy, err, res_ack,
    output altb, zero_b, busy, res_valid, quotient, remainder, res_err
  );
`endif
endinterface

// File: rtl/div_datapath.sv
// Repeated-subtraction divider datapath: working registers, compare flags and a
// valid/ack result register. Optional cycle counter under DIV_CYCLE_CNT_EN.
module div_datapath #(
  parameter int WIDTH = 8
`ifdef DIV_CYCLE_CNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic           clk,
  input  logic           rst,
  div_datapath_if.slave  bus
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             res_err_q, res_err_d;

  // Working registers: ini beats upd, and ini also beats a coincident rdy on busy.
  always_comb begin
    rem_d  = rem_q;
    b_d    = b_q;
    quo_d  = quo_q;
    busy_d = busy_q;
    if (bus.ini) begin
      rem_d  = bus.a_in;
      b_d    = bus.b_in;
      quo_d  = '0;
      busy_d = 1'b1;
    end else begin
      if (bus.upd) begin
        rem_d = rem_q - b_q;
        quo_d = quo_q + WIDTH'(1);
      end
      if (bus.rdy && !bus.err) busy_d = 1'b0;
    end
  end

  // Result register: a rdy always loads and wins over a same-cycle ack.
  always_comb begin
    res_valid_d = res_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    res_err_d   = res_err_q;
    if (bus.rdy) begin
      res_valid_d = 1'b1;
      if (bus.err) begin
        quotient_d  = '1;
        remainder_d = bus.a_in;
        res_err_d   = 1'b1;
      end else begin
        quotient_d  = quo_q;
        remainder_d = rem_q;
        res_err_d   = 1'b0;
      end
    end else if (bus.res_ack) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q       <= '0;
      b_q         <= '0;
      quo_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      b_q         <= b_d;
      quo_q       <= quo_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      res_err_q   <= res_err_d;
    end
  end

`ifdef DIV_CYCLE_CNT_EN
  logic [CNT_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;

  // Counts ini edge as 1 and includes the rdy edge; divide-by-zero reports 0.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (bus.rdy && bus.err)
      cyc_cnt_d = '0;
    else if (bus.ini)
      cyc_cnt_d = CNT_WIDTH'(1);
    else if (busy_q && (cyc_cnt_q != '1))
      cyc_cnt_d = cyc_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_cnt_q <= '0;
    else     cyc_cnt_q <= cyc_cnt_d;
  end

  assign bus.cyc_cnt = cyc_cnt_q;
`endif

  assign bus.altb      = (rem_q < b_q);
  assign bus.zero_b    = (bus.b_in == '0);
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_div_datapath.sv
// Directed bench for div_datapath; the bench plays the controller role.
module tb_div_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  div_datapath_if #(.WIDTH(8)) dif ();
  div_datapath #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(dif));

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled just after falling edges.
  task automatic do_ini(input logic [7:0] a, input logic [7:0] b);
    dif.a_in = a; dif.b_in = b; dif.ini = 1'b1;
    @(negedge clk); dif.ini = 1'b0;
  endtask

  task automatic do_upd(input int n);
    for (int i = 0; i < n; i++) begin
      dif.upd = 1'b1; @(negedge clk);
    end
    dif.upd = 1'b0;
  endtask

  task automatic do_rdy();
    dif.rdy = 1'b1; @(negedge clk); dif.rdy = 1'b0;
  endtask

  task automatic do_ack();
    dif.res_ack = 1'b1; @(negedge clk); dif.res_ack = 1'b0;
  endtask

  task automatic test_reset();
    dif.a_in = '0; dif.b_in = '0; dif.ini = 0; dif.upd = 0; dif.rdy = 0;
    dif.err = 0; dif.res_ack = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", dif.busy); end
    n_checks++; if (dif.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", dif.res_valid); end
    n_checks++; if (dif.quotient !== 8'd0 || dif.remainder !== 8'd0 || dif.res_err !== 1'b0)
      begin n_fail++; $display("FAIL reset_result got q=%0d r=%0d e=%0b exp 0/0/0", dif.quotient, dif.remainder, dif.res_err); end
    n_checks++; if (dif.altb !== 1'b0 || dif.zero_b !== 1'b1)
      begin n_fail++; $display("FAIL reset_flags got altb=%0b zero_b=%0b exp 0/1", dif.altb, dif.zero_b); end
`ifdef DIV_CYCLE_CNT_EN
    n_checks++; if (dif.cyc_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cyc got %0d exp 0", dif.cyc_cnt); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_ini(8'd13, 8'd4);
    n_checks++; if (dif.busy !== 1'b1 || dif.altb !== 1'b0 || dif.zero_b !== 1'b0)
      begin n_fail++; $display("FAIL basic_start got busy=%0b altb=%0b zero_b=%0b exp 1/0/0", dif.busy, dif.altb, dif.zero_b); end
    do_upd(2);
    n_checks++; if (dif.altb !== 1'b0) begin n_fail++; $display("FAIL basic_altb_mid got %0b exp 0", dif.altb); end
    do_upd(1);
    n_checks++; if (dif.altb !== 1'b1 || dif.res_valid !== 1'b0)
      begin n_fail++; $display("FAIL basic_pre_rdy got altb=%0b valid=%0b exp 1/0", dif.altb, dif.res_valid); end
    do_rdy();
    n_checks++; if (dif.res_valid !== 1'b1 || dif.quotient !== 8'd3 || dif.remainder !== 8'd1 || dif.res_err !== 1'b0 || dif.busy !== 1'b0)
      begin n_fail++; $display("FAIL basic_result got v=%0b q=%0d r=%0d e=%0b busy=%0b exp 1/3/1/0/0",
                              dif.res_valid, dif.quotient, dif.remainder, dif.res_err, dif.busy); end
`ifdef DIV_CYCLE_CNT_EN
    n_checks++; if (dif.cyc_cnt !== 16'd5) begin n_fail++; $display("FAIL basic_cyc got %0d exp 5", dif.cyc_cnt); end
`endif
    repeat (3) @(negedge clk);
    n_checks++; if (dif.res_valid !== 1'b1 || dif.quotient !== 8'd3)
      begin n_fail++; $display("FAIL basic_hold got v=%0b q=%0d exp 1/3", dif.res_valid, dif.quotient); end
    do_ack();
    n_checks++; if (dif.res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack got %0b exp 0", dif.res_valid); end
  endtask

  task automatic test_no_upd();
    do_ini(8'd3, 8'd5);
    n_checks++; if (dif.altb !== 1'b1) begin n_fail++; $display("FAIL noupd_altb got %0b exp 1", dif.altb); end
    do_rdy();
    n_checks++; if (dif.res_valid !== 1'b1 || dif.quotient !== 8'd0 || dif.remainder !== 8'd3)
      begin n_fail++; $display("FAIL noupd_result got v=%0b q=%0d r=%0d exp 1/0/3", dif.res_valid, dif.quotient, dif.remainder); end
`ifdef DIV_CYCLE_CNT_EN
    n_checks++; if (dif.cyc_cnt !== 16'd2) begin n_fail++; $display("FAIL noupd_cyc got %0d exp 2", dif.cyc_cnt); end
`endif
    do_ack();
  endtask

  task automatic test_div_zero();
    dif.a_in = 8'd7; dif.b_in = 8'd0;
    #1;
    n_checks++; if (dif.zero_b !== 1'b1) begin n_fail++; $display("FAIL dz_zero_b got %0b exp 1", dif.zero_b); end
    dif.err = 1'b1; @(negedge clk);
    n_checks++; if (dif.res_valid !== 1'b0 || dif.res_err !== 1'b0)
      begin n_fail++; $display("FAIL dz_err_only got v=%0b e=%0b exp 0/0", dif.res_valid, dif.res_err); end
    do_rdy(); dif.err = 1'b0;
    n_checks++; if (dif.res_valid !== 1'b1 || dif.quotient !== 8'hFF || dif.remainder !== 8'd7 || dif.res_err !== 1'b1)
      begin n_fail++; $display("FAIL dz_result got v=%0b q=%0h r=%0d e=%0b exp 1/ff/7/1",
                              dif.res_valid, dif.quotient, dif.remainder, dif.res_err); end
    n_checks++; if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy got %0b exp 0", dif.busy); end
`ifdef DIV_CYCLE_CNT_EN
    n_checks++; if (dif.cyc_cnt !== 16'd0) begin n_fail++; $display("FAIL dz_cyc got %0d exp 0", dif.cyc_cnt); end
`endif
    do_ack();
  endtask

  task automatic test_max();
    do_ini(8'd255, 8'd1);
    do_upd(254);
    n_checks++; if (dif.altb !== 1'b0 || dif.busy !== 1'b1)
      begin n_fail++; $display("FAIL max_mid got altb=%0b busy=%0b exp 0/1", dif.altb, dif.busy); end
    do_upd(1);
    n_checks++; if (dif.altb !== 1'b1) begin n_fail++; $display("FAIL max_altb got %0b exp 1", dif.altb); end
    do_rdy();
    n_checks++; if (dif.res_valid !== 1'b1 || dif.quotient !== 8'd255 || dif.remainder !== 8'd0 || dif.res_err !== 1'b0)
      begin n_fail++; $display("FAIL max_result got v=%0b q=%0d r=%0d e=%0b exp 1/255/0/0",
                              dif.res_valid, dif.quotient, dif.remainder, dif.res_err); end
`ifdef DIV_CYCLE_CNT_EN
    n_checks++; if (dif.cyc_cnt !== 16'd257) begin n_fail++; $display("FAIL max_cyc got %0d exp 257", dif.cyc_cnt); end
`endif
  endtask

  task automatic test_overwrite();
    do_ini(8'd9, 8'd2);
    n_checks++; if (dif.res_valid !== 1'b1 || dif.quotient !== 8'd255)
      begin n_fail++; $display("FAIL ow_old_kept got v=%0b q=%0d exp 1/255", dif.res_valid, dif.quotient); end
    do_upd(4);
    do_rdy();
    n_checks++; if (dif.res_valid !== 1'b1 || dif.quotient !== 8'd4 || dif.remainder !== 8'd1)
      begin n_fail++; $display("FAIL ow_result got v=%0b q=%0d r=%0d exp 1/4/1", dif.res_valid, dif.quotient, dif.remainder); end
`ifdef DIV_CYCLE_CNT_EN
    n_checks++; if (dif.cyc_cnt !== 16'd6) begin n_fail++; $display("FAIL ow_cyc got %0d exp 6", dif.cyc_cnt); end
`endif
    do_ack();
    n_checks++; if (dif.res_valid !== 1'b0) begin n_fail++; $display("FAIL ow_ack got %0b exp 0", dif.res_valid); end
  endtask

  task automatic test_back_to_back();
    do_ini(8'd3, 8'd5);
    do_rdy();
    do_ini(8'd6, 8'd6);
    do_upd(1);
    dif.res_ack = 1'b1; dif.rdy = 1'b1;
    @(negedge clk);
    dif.res_ack = 1'b0; dif.rdy = 1'b0;
    n_checks++; if (dif.res_valid !== 1'b1 || dif.quotient !== 8'd1 || dif.remainder !== 8'd0)
      begin n_fail++; $display("FAIL b2b_rdy_ack got v=%0b q=%0d r=%0d exp 1/1/0", dif.res_valid, dif.quotient, dif.remainder); end
  endtask

  task automatic test_reset_mid();
    do_ini(8'd200, 8'd3);
    do_upd(10);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (dif.busy !== 1'b0 || dif.res_valid !== 1'b0 || dif.quotient !== 8'd0 || dif.remainder !== 8'd0)
      begin n_fail++; $display("FAIL rstmid_out got busy=%0b v=%0b q=%0d r=%0d exp 0/0/0/0",
                              dif.busy, dif.res_valid, dif.quotient, dif.remainder); end
    n_checks++; if (dif.altb !== 1'b0) begin n_fail++; $display("FAIL rstmid_altb got %0b exp 0", dif.altb); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    do_rdy();
    n_checks++; if (dif.res_valid !== 1'b1 || dif.quotient !== 8'd0 || dif.remainder !== 8'd0)
      begin n_fail++; $display("FAIL rstmid_stale_rdy got v=%0b q=%0d r=%0d exp 1/0/0", dif.res_valid, dif.quotient, dif.remainder); end
    do_ack();
    do_ini(8'd10, 8'd3);
    do_upd(3);
    do_rdy();
    n_checks++; if (dif.res_valid !== 1'b1 || dif.quotient !== 8'd3 || dif.remainder !== 8'd1)
      begin n_fail++; $display("FAIL rstmid_new got v=%0b q=%0d r=%0d exp 1/3/1", dif.res_valid, dif.quotient, dif.remainder); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_upd();
    test_div_zero();
    test_max();
    test_overwrite();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
